// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencing controller: owns HI/LO, runs a 2-cycle registered
// multiply or a WIDTH-step restoring divide, and services mthi/mtlo and flush.
//
// state | meaning
// IDLE  | accepting start, wr_hi/wr_lo; hi/lo stable
// MUL   | operands latched, product written at end of this cycle
// DIV   | one restoring shift/subtract step per cycle on magnitudes
// FIX   | sign correction of quotient/remainder, result written
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             legal_op;
    logic             sgn_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    assign legal_op = (op == 4'b0000) || (op == 4'b0001) ||
                      (op == 4'b1000) || (op == 4'b1001);
    assign sgn_in   = ~op[3];
    assign a_mag    = (sgn_in && a[WIDTH-1]) ? -a : a;
    assign b_mag    = (sgn_in && b[WIDTH-1]) ? -b : b;

    // Extending both operands to 2*WIDTH makes the truncated product correct
    // for signed and unsigned alike.
    assign prod   = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q} *
                    {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
    assign rem_sh = {rem_q, opa_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, opb_q};

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start && legal_op) begin
                    sgn_d = sgn_in;
                    opa_d = a;
                    opb_d = b;
                    if (!op[0]) begin
                        state_d = S_MUL;
                    end else if (b == '0) begin
                        lo_d   = '1;
                        hi_d   = a;
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        rem_d   = '0;
                        opa_d   = a_mag;
                        opb_d   = b_mag;
                        negq_d  = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                        negr_d  = sgn_in & a[WIDTH-1];
                    end
                end
            end
            S_MUL: begin
                {hi_d, lo_d} = prod;
                done_d       = 1'b1;
                state_d      = S_IDLE;
            end
            S_DIV: begin
                // opa_q shifts out dividend bits at the top and quotient bits in at the bottom
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    opa_d = {opa_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    opa_d = {opa_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                lo_d    = negq_q ? -opa_q : opa_q;
                hi_d    = negr_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (cancel) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dz_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the CPU's multiply/divide resource. It owns the architectural HI/LO registers and accepts one multiply or divide request at a time from the execute stage. Multiplies run as a registered 2-cycle operation; divides run as a 32-iteration restoring divider. While an operation is in flight it asserts `busy` so the pipeline stalls any HI/LO consumer. It also services direct HI/LO writes (mthi/mtlo) and aborts on pipeline flush.

## Interface
- WIDTH, 32, operand and HI/LO width; the divider iteration count equals WIDTH.

- clk  in  1  clock; one clock domain, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  4  operation: 0000 signed mul, 0001 signed div, 1000 unsigned mul, 1001 unsigned div.
- a, b  in  WIDTH each  operands (dividend/divisor for div); latched on an accepted start.
- cancel  in  1  flush; aborts any in-flight operation.
- wr_hi, wr_lo  in  1 each  direct HI/LO write strobes.
- wdata  in  WIDTH  data for wr_hi/wr_lo.
- busy  out  1  operation in flight (state != IDLE).
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div_zero  out  1  pulses with done when the completed divide had b == 0.
- hi, lo  out  WIDTH each  architectural HI/LO register contents.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + start + legal op: latch a, b, op; mul -> MUL; div with b != 0 -> DIV (iteration counter = 0); div with b == 0 -> stays IDLE and writes the divide-by-zero result.
- start with an illegal op (any code other than the four above): ignored, no state change, no done.
- MUL: product = a*b, computed as 2*WIDTH-bit signed or unsigned per op[3]; {hi,lo} <= product at end of cycle; -> IDLE.
- DIV: the divider operates on magnitudes; for a signed op a negative operand is negated first. Each cycle performs one restoring shift/subtract step and counter++. After WIDTH steps -> FIX.
- FIX: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); both apply only for a signed op. lo <= quotient, hi <= remainder; -> IDLE.
- Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. This falls out of the magnitude arithmetic and needs no special case.
- Divide by zero: lo <= all ones, hi <= a, div_zero = 1 with done.
- wr_hi/wr_lo: honoured only in IDLE and take effect at that edge. Ignored while busy. If a write and an accepted start occur in the same cycle, the write takes effect and the later result overwrites it.
- cancel: in any state, go to IDLE next edge. HI/LO are left unchanged, no done, and any wr/start in that cycle is ignored.
- rst: state IDLE, hi = lo = 0, busy = done = div_zero = 0. Reset overrides everything, mid-operation included.

## Timing
- Cycle 0 is the start-accepted cycle (IDLE, start = 1).
- Multiply: busy = 1 in cycle 1. Cycle 2: IDLE, done = 1, new hi/lo visible. Latency 2.
- Divide: DIV in cycles 1..WIDTH, FIX in cycle WIDTH+1, done in cycle WIDTH+2 (34 for WIDTH = 32).
- Divide by zero: done = div_zero = 1 in cycle 1; busy never asserts.
- done and div_zero are registered single-cycle pulses.
- A new start may be accepted in the same cycle done is high (back-to-back issue).
- hi/lo outputs are register outputs. They change only at the result-write edge, a wr_* edge, or reset; they are never intermediate divider values.

## Test plan
- Unsigned mul a=0xFFFFFFFF, b=2 -> done at cycle 2, hi=0x00000001, lo=0xFFFFFFFE. Signed mul, same operands -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Signed div a=-7 (0xFFFFFFF9), b=2 -> busy cycles 1–33, done at cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned div, same operands -> lo=0x7FFFFFFC, hi=1.
- Signed div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Any div with b=0, a=0x1234 -> done and div_zero in cycle 1, lo=0xFFFFFFFF, hi=0x1234.
- Divide started, cancel in cycle 10 -> IDLE at cycle 11, no done, hi/lo equal to pre-start values. Repeat with rst in cycle 10 -> hi=lo=0.
- wr_hi with wdata=0xAA while busy -> no effect. wr_lo with 0x55 in IDLE -> lo=0x55 next cycle. Mul issued in the same cycle as its predecessor's done -> accepted, result at +2.
- start with op=0100 -> busy stays 0, no done, hi/lo unchanged.
